game_level_ctl: RTL and testbench

- Level sequencer that drives the top-level game state machine (START=0, NEXT_LEVEL=1, FAIL=2, FINISH=3, GAME=4).
- Owns the level number, the lives count, the per-level countdown timer and the per-level hit quota.
- Generates single-cycle next_lvl / fail pulses back to the state machine, and supplies lvl for its FINISH decision (lvl > 3).
- Sits between gameplay logic (hit/miss pulses) and the state machine; also feeds the HUD text.

---
 rtl/game_pkg.sv | 39 +++
 rtl/game_tick_gen.sv | 38 +++
 rtl/game_level_ctl.sv | 140 ++++++++++++++
 tb/tb_game_level_ctl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared encodings and helpers for the level sequencer.
//   - game_state_e : top-level game state machine encodings (3-bit)
//   - lvl_st_e     : internal level-sequencer states
//   - LVL_W        : level counter width
//   - MAX_LVL      : last playable level (FINISH once lvl exceeds it)
//   - hits_quota() : hits needed to clear a level, saturated to 8 bits
package game_pkg;

    localparam int LVL_W   = 13;
    localparam int MAX_LVL = 3;

    typedef enum logic [2:0] {
        GS_START      = 3'd0,
        GS_NEXT_LEVEL = 3'd1,
        GS_FAIL       = 3'd2,
        GS_FINISH     = 3'd3,
        GS_GAME       = 3'd4
    } game_state_e;

    typedef enum logic [1:0] {
        LC_IDLE = 2'd0,
        LC_ARM  = 2'd1,
        LC_RUN  = 2'd2,
        LC_DONE = 2'd3
    } lvl_st_e;

    // base + step*(lvl-1) evaluated in 16 bits, then clamped to what the
    // 8-bit HUD counter can hold.
    function automatic logic [7:0] hits_quota(input logic [LVL_W-1:0] lvl,
                                              input int unsigned base,
                                              input int unsigned step);
        logic [LVL_W-1:0] lvl_m1;
        logic [15:0]      need;
        lvl_m1 = lvl - LVL_W'(1);
        need   = 16'(base) + 16'(step) * {{(16-LVL_W){1'b0}}, lvl_m1};
        return (need > 16'd255) ? 8'd255 : need[7:0];
    endfunction

endpackage

// File: rtl/game_tick_gen.sv
// game_tick_gen: one-second prescaler for the level timer.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   clr    in  synchronous clear of the prescaler (count restarts at 0)
//   tick   out one-cycle pulse in the cycle the count wraps TICK_DIV-1 -> 0
module game_tick_gen #(
    parameter int unsigned TICK_DIV = 65_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned          CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/game_level_ctl.sv
// game_level_ctl: level sequencer beneath the game state machine. Owns level
// number, lives, per-level countdown and hit quota; reports level completion
// (next_lvl) or failure (fail) as registered one-cycle pulses.
//   clk, rst_n   clock, asynchronous active-low reset
//   game_state   current state of the game state machine
//   hit, miss    one-cycle gameplay pulses
//   lvl          current level (1-based), lives, time_left, hits_left: HUD/FSM
//   next_lvl     one-cycle pulse, level cleared
//   fail         one-cycle pulse, timer expired or last life lost
//
// state | meaning
// IDLE  | waiting for GAME; START reloads level and lives
// ARM   | one cycle: load timer and quota, restart prescaler
// RUN   | level in play: count ticks, hits, misses
// DONE  | outcome reported; counters frozen until game_state leaves GAME
module game_level_ctl
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 65_000_000,
    parameter int unsigned LVL_TIME  = 60,
    parameter int unsigned BASE_HITS = 5,
    parameter int unsigned HITS_STEP = 2,
    parameter int unsigned LIVES     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       game_state,
    input  logic             hit,
    input  logic             miss,
    output logic [LVL_W-1:0] lvl,
    output logic [1:0]       lives,
    output logic [7:0]       time_left,
    output logic [7:0]       hits_left,
    output logic             next_lvl,
    output logic             fail
);

    localparam logic [LVL_W-1:0] LVL_SAT = '1;

    lvl_st_e          st_q, st_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [1:0]       lives_q, lives_d;
    logic [7:0]       time_q, time_d;
    logic [7:0]       hits_q, hits_d;
    logic             next_q, next_d;
    logic             fail_q, fail_d;

    logic tick;
    logic in_game;
    logic fail_c;
    logic comp_c;

    game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (st_q == LC_ARM),
        .tick  (tick)
    );

    assign in_game = (game_state == GS_GAME);
    assign fail_c  = (tick && time_q == 8'd1) || (miss && lives_q == 2'd1);
    assign comp_c  = hit && hits_q == 8'd1;

    always_comb begin
        st_d    = st_q;
        lvl_d   = lvl_q;
        lives_d = lives_q;
        time_d  = time_q;
        hits_d  = hits_q;
        next_d  = 1'b0;
        fail_d  = 1'b0;
        case (st_q)
            LC_IDLE: begin
                if (game_state == GS_START) begin
                    lvl_d   = LVL_W'(1);
                    lives_d = 2'(LIVES);
                end else if (in_game) begin
                    st_d = LC_ARM;
                end
            end
            LC_ARM: begin
                time_d = 8'(LVL_TIME);
                hits_d = hits_quota(lvl_q, BASE_HITS, HITS_STEP);
                st_d   = LC_RUN;
            end
            LC_RUN: begin
                if (!in_game) begin
                    st_d = LC_IDLE;
                end else begin
                    // Counters only step down from non-zero; the terminal
                    // step of the one that fails is its write to 0.
                    if (tick && time_q != 8'd0)  time_d  = time_q - 8'd1;
                    if (hit && hits_q != 8'd0)   hits_d  = hits_q - 8'd1;
                    if (miss && lives_q != 2'd0) lives_d = lives_q - 2'd1;
                    // Fail outranks completion, as the state machine does.
                    if (fail_c) begin
                        fail_d = 1'b1;
                        st_d   = LC_DONE;
                    end else if (comp_c) begin
                        next_d = 1'b1;
                        if (lvl_q != LVL_SAT) lvl_d = lvl_q + LVL_W'(1);
                        st_d   = LC_DONE;
                    end
                end
            end
            LC_DONE: begin
                if (!in_game) st_d = LC_IDLE;
            end
            default: st_d = LC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= LC_IDLE;
            lvl_q   <= LVL_W'(1);
            lives_q <= 2'(LIVES);
            time_q  <= 8'd0;
            hits_q  <= 8'd0;
            next_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            lvl_q   <= lvl_d;
            lives_q <= lives_d;
            time_q  <= time_d;
            hits_q  <= hits_d;
            next_q  <= next_d;
            fail_q  <= fail_d;
        end
    end

    assign lvl       = lvl_q;
    assign lives     = lives_q;
    assign time_left = time_q;
    assign hits_left = hits_q;
    assign next_lvl  = next_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_game_level_ctl.sv
// Scoreboard bench for game_level_ctl: the driver runs a per-level reference
// model and queues the expected outcome; a negedge monitor pops and checks
// each next_lvl/fail pulse.
module tb_game_level_ctl;
    import game_pkg::*;

    localparam int TD = 4;
    localparam int LT = 3;
    localparam int BH = 2;
    localparam int HS = 2;
    localparam int LV = 3;

    localparam int M_HITS   = 0;
    localparam int M_NONE   = 1;
    localparam int M_MISS   = 2;
    localparam int M_SCRIPT = 3;
    localparam int M_RAND   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       gs;
    logic             hit, miss;
    logic [LVL_W-1:0] lvl;
    logic [1:0]       lives;
    logic [7:0]       time_left, hits_left;
    logic             next_lvl, fail;

    always #5 clk = ~clk;

    game_level_ctl #(
        .TICK_DIV(TD), .LVL_TIME(LT), .BASE_HITS(BH), .HITS_STEP(HS), .LIVES(LV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .game_state(gs), .hit(hit), .miss(miss),
        .lvl(lvl), .lives(lives), .time_left(time_left), .hits_left(hits_left),
        .next_lvl(next_lvl), .fail(fail)
    );

    typedef struct {
        bit is_fail;
        int lvl;
        int lives;
        int tl;
        int hl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   m_lvl, m_lives, m_time, m_hits;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int quota(input int l);
        int q;
        q = BH + HS * (l - 1);
        return (q > 255) ? 255 : q;
    endfunction

    always @(negedge clk) begin
        if (rst_n && (next_lvl || fail)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pulse: next_lvl=%0b fail=%0b, none expected (t=%0t)",
                         next_lvl, fail, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_next_lvl", int'(next_lvl), int'(!mon_e.is_fail));
                chk("pulse_fail",     int'(fail),     int'(mon_e.is_fail));
                chk("pulse_lvl",      int'(lvl),      mon_e.lvl);
                chk("pulse_lives",    int'(lives),    mon_e.lives);
                chk("pulse_time",     int'(time_left), mon_e.tl);
                chk("pulse_hits",     int'(hits_left), mon_e.hl);
            end
        end
    end

    function automatic void stim(input int mode, input int k, output bit h, output bit m);
        h = 1'b0;
        m = 1'b0;
        case (mode)
            M_HITS:   h = 1'b1;
            M_MISS:   m = (k % 2 == 0);
            M_SCRIPT: begin
                h = (k == 2) || (k == 3);
                m = (k == 0) || (k == 1) || (k == 3);
            end
            M_RAND: begin
                h = ($urandom_range(0, 2) == 0);
                m = ($urandom_range(0, 9) == 0);
            end
            default: ;
        endcase
    endfunction

    task automatic check_counters(input string tag);
        chk({tag, "_lvl"},   int'(lvl),       m_lvl);
        chk({tag, "_lives"}, int'(lives),     m_lives);
        chk({tag, "_time"},  int'(time_left), m_time);
        chk({tag, "_hits"},  int'(hits_left), m_hits);
    endtask

    task automatic goto(input logic [2:0] s);
        gs = s;
        repeat (2) begin
            @(posedge clk); #1;
        end
        if (s == GS_START) begin
            m_lvl   = 1;
            m_lives = LV;
        end
    endtask

    task automatic run_level(input int mode, input int abort_at);
        bit   h, m, tk, f_c, c_c, done;
        exp_t e;
        gs = GS_GAME;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_time = LT;
        m_hits = quota(m_lvl);
        check_counters("arm");
        done = 1'b0;
        for (int k = 0; k < LT * TD + 4 && !done; k++) begin
            if (k == abort_at) begin
                gs = GS_NEXT_LEVEL;
                hit = 1'b0;
                miss = 1'b0;
                @(posedge clk); #1;
                @(posedge clk); #1;
                check_counters("abort");
                return;
            end
            stim(mode, k, h, m);
            hit  = h;
            miss = m;
            tk  = ((k % TD) == TD - 1);
            f_c = (tk && m_time == 1) || (m && m_lives == 1);
            c_c = h && m_hits == 1;
            if (tk && m_time > 0) m_time--;
            if (h && m_hits > 0)  m_hits--;
            if (m && m_lives > 0) m_lives--;
            if (f_c || c_c) begin
                if (!f_c && m_lvl < 8191) m_lvl++;
                e.is_fail = f_c;
                e.lvl = m_lvl;
                e.lives = m_lives;
                e.tl = m_time;
                e.hl = m_hits;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        // hit/miss are ignored in DONE
        for (int w = 0; w < 3; w++) begin
            hit  = 1'($urandom_range(0, 1));
            miss = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        hit  = 1'b0;
        miss = 1'b0;
        chk("pulse_seen", sb.size(), 0);
        check_counters("done");
    endtask

    initial begin
        gs = GS_START;
        hit = 1'b0;
        miss = 1'b0;
        m_lvl = 1; m_lives = LV; m_time = 0; m_hits = 0;
        #12;
        check_counters("reset");
        chk("reset_next_lvl", int'(next_lvl), 0);
        chk("reset_fail", int'(fail), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        goto(GS_START);
        run_level(M_HITS, -1);        // clears level 1, lvl -> 2
        goto(GS_NEXT_LEVEL);
        run_level(M_NONE, -1);        // quota 4, timer runs out
        goto(GS_NEXT_LEVEL);
        run_level(M_MISS, -1);        // lives 3 -> 0
        goto(GS_START);
        run_level(M_SCRIPT, -1);      // completion and last life in one cycle
        goto(GS_START);
        run_level(M_HITS, 1);         // leave GAME mid-level
        goto(GS_NEXT_LEVEL);

        // asynchronous reset in the middle of a level
        gs = GS_GAME;
        repeat (7) begin
            @(posedge clk); #1;
        end
        #3;
        rst_n = 1'b0;
        #1;
        m_lvl = 1; m_lives = LV; m_time = 0; m_hits = 0;
        check_counters("midrst");
        chk("midrst_next_lvl", int'(next_lvl), 0);
        chk("midrst_fail", int'(fail), 0);
        gs = GS_START;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            run_level(M_RAND, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 8)) : -1);
            if (m_lives == 0 || m_lvl > MAX_LVL || $urandom_range(0, 3) == 0)
                goto(GS_START);
            else
                goto(GS_NEXT_LEVEL);
        end

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
